seg_readback: RTL and testbench

Loop-back reader for the lock's multiplexed 7-segment display bus. It samples the active-low segment lines (ABCDEFG) and active-low digit anodes that the display scanner drives, and waits until each pattern is stable. It then inverts the character encoding back into the 5-bit character codes and stores one code per digit. Self-test logic uses the recovered codes to confirm that the digits shown match the digits the lock intended to display.

---
 rtl/seg_readback.sv | 185 ++++++++++++++++++
 tb/tb_seg_readback.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_readback.sv
// Loop-back reader for the multiplexed 7-segment bus: waits for a stable
// (anode, segment) pattern, decodes it back to a 5-bit character code per digit.
module seg_readback #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [19:0] codes,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        bad_pattern
);

  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] STABLE_FULL = 8'(STABLE_CYCLES);
  localparam logic [4:0] CODE_BLANK  = 5'd22;
  localparam logic [4:0] CODE_BAD    = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [10:0] hold_reg, hold_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  mask_reg;
  logic [3:0]  digit_valid_reg;
  logic        frame_done_reg;
  logic        bad_pattern_reg;
  logic [4:0]  code_reg [4];

  logic [3:0]  sel;
  logic        sample_valid;
  logic        sample_same;
  logic        capture;
  logic [4:0]  decoded;
  logic [3:0]  mask_merged;

  // Inverse of the display character map; unknown patterns decode to 31.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] c;
    case (p)
      7'b0000001: c = 5'd0;
      7'b1001111: c = 5'd1;
      7'b0010010: c = 5'd2;
      7'b0000110: c = 5'd3;
      7'b1001100: c = 5'd4;
      7'b0100100: c = 5'd5;
      7'b0100000: c = 5'd6;
      7'b0001111: c = 5'd7;
      7'b0000000: c = 5'd8;
      7'b0000100: c = 5'd9;
      7'b0001000: c = 5'd10;
      7'b1100000: c = 5'd11;
      7'b0110001: c = 5'd12;
      7'b1000010: c = 5'd13;
      7'b0110000: c = 5'd14;
      7'b0111000: c = 5'd15;
      7'b1110001: c = 5'd16;
      7'b0011000: c = 5'd17;
      7'b1101010: c = 5'd18;
      7'b1000001: c = 5'd19;
      7'b1111110: c = 5'd20;
      7'b1110111: c = 5'd21;
      7'b1111111: c = 5'd22;
      default:    c = CODE_BAD;
    endcase
    return c;
  endfunction

  // A sample is valid only when exactly one anode is driven.
  always_comb begin
    sel          = ~an;
    sample_valid = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
    sample_same  = ({an, seg} == hold_reg);
    decoded      = decode(seg);
    mask_merged  = mask_reg | sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hold_reg  <= '1;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sample_valid) begin
          hold_next  = {an, seg};
          cnt_next   = 8'd1;
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (!sample_valid) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (sample_same) begin
          if (cnt_reg == STABLE_LAST) begin
            cnt_next   = STABLE_FULL;
            capture    = 1'b1;
            state_next = HELD;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end else begin
          hold_next = {an, seg};
          cnt_next  = 8'd1;
        end
      end
      HELD: begin
        if (!sample_valid) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (!sample_same) begin
          hold_next  = {an, seg};
          cnt_next   = 8'd1;
          state_next = TRACK;
        end
      end
      default: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          code_reg[gi]        <= CODE_BLANK;
          digit_valid_reg[gi] <= 1'b0;
        end else if (capture && sel[gi]) begin
          code_reg[gi]        <= decoded;
          digit_valid_reg[gi] <= 1'b1;
        end
      end
      assign codes[5*gi +: 5] = code_reg[gi];
    end
  endgenerate

  // The frame mask clears on the capture that completes it, so each
  // frame_done marks four fresh digit captures.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_reg        <= 4'b0000;
      frame_done_reg  <= 1'b0;
      bad_pattern_reg <= 1'b0;
    end else begin
      frame_done_reg  <= 1'b0;
      bad_pattern_reg <= 1'b0;
      if (capture) begin
        bad_pattern_reg <= (decoded == CODE_BAD);
        if (mask_merged == 4'b1111) begin
          mask_reg       <= 4'b0000;
          frame_done_reg <= 1'b1;
        end else begin
          mask_reg <= mask_merged;
        end
      end
    end
  end

  assign digit_valid = digit_valid_reg;
  assign frame_done  = frame_done_reg;
  assign bad_pattern = bad_pattern_reg;

endmodule

// File: tb/tb_seg_readback.sv
// Randomized and directed bench for seg_readback against a run-length
// reference model of the display loop-back.
module tb_seg_readback;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7f;
  logic [3:0]  an = 4'hf;
  logic [19:0] codes;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        bad_pattern;

  seg_readback #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .codes(codes), .digit_valid(digit_valid),
    .frame_done(frame_done), .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0]  pat [23];
  logic [4:0]  m_codes [4];
  logic [3:0]  m_dv, m_mask;
  logic        m_fd, m_bad;
  int          run_len;
  logic [10:0] last;
  int          fd_seen, bad_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_code(input logic [6:0] s);
    for (int i = 0; i < 23; i++)
      if (pat[i] == s) return 5'(i);
    return 5'd31;
  endfunction

  function automatic logic [19:0] m_packed();
    return {m_codes[3], m_codes[2], m_codes[1], m_codes[0]};
  endfunction

  // Model: a capture happens exactly when the current run of identical
  // valid samples reaches length S.
  task automatic model_edge(input logic r, input logic [3:0] a, input logic [6:0] s);
    int idx;
    logic [4:0] c;
    m_fd  = 1'b0;
    m_bad = 1'b0;
    if (!r) begin
      for (int i = 0; i < 4; i++) m_codes[i] = 5'd22;
      m_dv = 4'h0; m_mask = 4'h0; run_len = 0; last = '1;
    end else if ($countones(~a) == 1) begin
      if (run_len > 0 && {a, s} == last) run_len++;
      else run_len = 1;
      last = {a, s};
      if (run_len == S) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
        c = ref_code(s);
        m_codes[idx] = c;
        m_dv[idx] = 1'b1;
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hf) begin
          m_fd = 1'b1;
          m_mask = 4'h0;
        end
        m_bad = (c == 5'd31);
        $display("capture digit %0d seg %07b code %0d frame %0d", idx, s, c, m_fd);
      end
    end else begin
      run_len = 0;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    @(negedge clk);
    rst_n = r; an = a; seg = s;
    @(posedge clk);
    model_edge(r, a, s);
    #1;
    check("codes", 32'(codes), 32'(m_packed()));
    check("digit_valid", 32'(digit_valid), 32'(m_dv));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
    fd_seen  += int'(frame_done);
    bad_seen += int'(bad_pattern);
  endtask

  task automatic hold(input int n, input logic [3:0] a, input logic [6:0] s);
    for (int i = 0; i < n; i++) step(1'b1, a, s);
  endtask

  initial begin
    logic [6:0] scan [4];
    logic [3:0] ra;
    logic [6:0] rs;
    pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
            7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
            7'b0111000, 7'b1110001, 7'b0011000, 7'b1101010, 7'b1000001,
            7'b1111110, 7'b1110111, 7'b1111111};
    scan = '{7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
    fd_seen = 0; bad_seen = 0;

    // Reset
    step(1'b0, 4'hf, 7'h7f);
    step(1'b0, 4'hf, 7'h7f);
    check("reset_codes", 32'(codes), 32'({4{5'b10110}}));
    check("reset_valid", 32'(digit_valid), 32'd0);

    // Single capture, then a long hold with no recapture
    hold(3, 4'b1110, 7'b0010010);
    check("pre_capture", 32'(codes[4:0]), 32'd22);
    hold(1, 4'b1110, 7'b0010010);
    check("single_code", 32'(codes[4:0]), 32'd2);
    check("single_valid", 32'(digit_valid), 32'b0001);
    hold(10, 4'b1110, 7'b0010010);

    // Glitch rejection: a 3-cycle run must not be captured
    hold(3, 4'b1101, 7'b0000110);
    check("glitch_skip", 32'(codes[9:5]), 32'd22);
    hold(4, 4'b1101, 7'b1001100);
    check("glitch_code", 32'(codes[9:5]), 32'd4);

    // Two full scans, one frame_done each
    for (int f = 0; f < 2; f++) begin
      fd_seen = 0;
      for (int d = 0; d < 4; d++) hold(S, ~(4'b0001 << d), scan[d]);
      check("frame_codes", 32'(codes), 32'({5'd13, 5'd12, 5'd11, 5'd10}));
      check("frame_pulses", 32'(fd_seen), 32'd1);
    end

    // Unknown pattern
    bad_seen = 0;
    hold(S, 4'b1011, 7'b1010101);
    check("bad_code", 32'(codes[14:10]), 32'd31);
    check("bad_pulses", 32'(bad_seen), 32'd1);

    // Two anodes low never captures; all-high breaks the run
    hold(10, 4'b1100, 7'b0000000);
    hold(3, 4'b0111, 7'b0100100);
    hold(1, 4'b1111, 7'b0100100);
    hold(3, 4'b0111, 7'b0100100);
    check("broken_run", 32'(codes[19:15]), 32'd13);
    hold(1, 4'b0111, 7'b0100100);
    check("rejoined_run", 32'(codes[19:15]), 32'd5);

    // Reset mid-run restarts the count
    hold(3, 4'b1110, 7'b0001111);
    step(1'b0, 4'b1110, 7'b0001111);
    hold(3, 4'b1110, 7'b0001111);
    check("rst_no_early", 32'(codes[4:0]), 32'd22);
    hold(1, 4'b1110, 7'b0001111);
    check("rst_capture", 32'(codes[4:0]), 32'd7);

    // Random runs
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = 4'($urandom);
        default: ra = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 4) == 0) rs = 7'($urandom);
      else rs = pat[$urandom_range(0, 22)];
      if ($urandom_range(0, 59) == 0) step(1'b0, ra, rs);
      else hold($urandom_range(1, 7), ra, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
